// File: rtl/step_controller_if.sv
// Datapath-facing handshake and debug/status bundle of the step controller.
// master: the step controller; slave: the datapath / debug display side.
interface step_controller_if #(
  parameter int STEP_CNT_W = 16
);
  logic                  instr_retired;
  logic                  finish;
  logic                  run_en;
  logic                  step_active;
  logic                  done;
  logic [1:0]            state_o;
  logic [STEP_CNT_W-1:0] step_count;
  logic                  timeout;

  modport master (
    input  instr_retired, finish,
    output run_en, step_active, done, state_o, step_count, timeout
  );

  modport slave (
    output instr_retired, finish,
    input  run_en, step_active, done, state_o, step_count, timeout
  );
endinterface

// File: rtl/step_controller.sv
// Execution-control stage in front of the datapath: synchronizes the stepping
// switch and next-instruction button, debounces the button, and runs a
// RUN/HALT/STEP/DONE FSM that produces the registered pipeline enable.
// Optional build macro STEP_TIMEOUT_EN adds a watchdog that aborts a STEP
// that has not retired within TIMEOUT_CYCLES cycles and sets a sticky flag.
module step_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          STEP_CNT_W      = 16,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1024
) (
  input  logic               clkFPGA,
  input  logic               rst_n,
  input  logic               stepping_flag,
  input  logic               next_instr,
  step_controller_if.master  bus
);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HALT = 2'b01,
    S_STEP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Synchronizers and debouncer
  logic        step_s1_q, step_s1_d, step_s_q, step_s_d;
  logic        btn_s1_q, btn_s1_d, btn_s_q, btn_s_d;
  logic        deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic        press_evt;

  // FSM and registered outputs
  state_t                state_q, state_d;
  logic                  run_en_q, run_en_d;
  logic                  step_active_q, step_active_d;
  logic                  done_q, done_d;
  logic [STEP_CNT_W-1:0] step_count_q, step_count_d;
  logic                  tmo_expired;

  // Next values for the synchronizer chains and the button debouncer
  always_comb begin
    step_s1_d  = stepping_flag;
    step_s_d   = step_s1_q;
    btn_s1_d   = next_instr;
    btn_s_d    = btn_s1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    deb_cnt_d  = deb_cnt_q;
    if (btn_s_q == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q >= DEBOUNCE_CYCLES - 16'd1) begin
      deb_d     = btn_s_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 16'd1;
    end
  end

  // Input conditioning flops; the stepping switch syncs reset to 1 so a
  // freshly reset controller stays halted until the switch is really seen low
  always_ff @(posedge clkFPGA or negedge rst_n) begin
    if (!rst_n) begin
      step_s1_q  <= 1'b1;
      step_s_q   <= 1'b1;
      btn_s1_q   <= 1'b0;
      btn_s_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      step_s1_q  <= step_s1_d;
      step_s_q   <= step_s_d;
      btn_s1_q   <= btn_s1_d;
      btn_s_q    <= btn_s_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // Only a rising debounced level is a press; the release edge is ignored
  assign press_evt = deb_q & ~deb_prev_q;

`ifdef STEP_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;

  assign tmo_expired = (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1);

  // Watchdog: restart on STEP entry, count every STEP cycle, latch on expiry
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    if (state_q != S_STEP) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
      if (!bus.instr_retired && tmo_expired) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Watchdog flops
  always_ff @(posedge clkFPGA or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign tmo_expired = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next-state logic; finish overrides every other transition
  always_comb begin
    state_d      = state_q;
    step_count_d = step_count_q;
    unique case (state_q)
      S_RUN: begin
        if (step_s_q) state_d = S_HALT;
      end
      S_HALT: begin
        if (!step_s_q)     state_d = S_RUN;
        else if (press_evt) state_d = S_STEP;
      end
      S_STEP: begin
        if (bus.instr_retired) begin
          state_d      = step_s_q ? S_HALT : S_RUN;
          step_count_d = step_count_q + 1'b1;
        end else if (tmo_expired) begin
          state_d = S_HALT;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_HALT;
    endcase
    if (bus.finish) state_d = S_DONE;
  end

  // Output decode from the next state so outputs flip on the same edge as state
  always_comb begin
    run_en_d      = (state_d == S_RUN) || (state_d == S_STEP);
    step_active_d = (state_d == S_STEP);
    done_d        = (state_d == S_DONE);
  end

  // State and registered output flops
  always_ff @(posedge clkFPGA or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HALT;
      run_en_q      <= 1'b0;
      step_active_q <= 1'b0;
      done_q        <= 1'b0;
      step_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      run_en_q      <= run_en_d;
      step_active_q <= step_active_d;
      done_q        <= done_d;
      step_count_q  <= step_count_d;
    end
  end

  assign bus.run_en      = run_en_q;
  assign bus.step_active = step_active_q;
  assign bus.done        = done_q;
  assign bus.state_o     = state_q;
  assign bus.step_count  = step_count_q;

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Execution-control stage directly upstream of the datapath.
- Turns the board-level stepping switch (stepping_flag) and the next-instruction push button (next_instr) into a registered pipeline enable (run_en) that the datapath consumes.
- Supports free-run, halted, and single-instruction stepping; halts permanently once the datapath raises finish.
- Exposes a step counter and state code for the debug/counter display path.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, consecutive identical synced samples required before the debounced next_instr level changes; minimum 2.
- STEP_CNT_W, 16, width of step_count.
- TIMEOUT_CYCLES, 32'd1024, maximum STEP duration; used only with STEP_TIMEOUT_EN.

Ports:
- clkFPGA  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stepping_flag  in  1  raw switch; 1 = stepping mode; asynchronous.
- next_instr  in  1  raw push button; 1 = pressed; asynchronous, bouncy.
- instr_retired  in  1  one-cycle pulse from datapath when an instruction completes writeback; clkFPGA domain.
- finish  in  1  datapath program-end flag; clkFPGA domain, level.
- run_en  out  1  pipeline advance enable to datapath.
- step_active  out  1  high while in STEP.
- done  out  1  sticky program-finished indicator.
- state_o  out  2  00 RUN, 01 HALT, 10 STEP, 11 DONE.
- step_count  out  STEP_CNT_W  completed single steps.
- timeout  out  1  sticky step timeout flag; tied 0 without STEP_TIMEOUT_EN.

Behaviour:
- All flops asynchronously cleared by rst_n low; outputs take reset values immediately, mid-operation included.
- Reset values: state HALT, run_en 0, step_active 0, done 0, step_count 0, timeout 0.
- Synchronizer reset values: stepping_flag sync FFs reset to 1 (halted-safe); next_instr sync FFs reset to 0.
- Synchronization: stepping_flag and next_instr each pass through 2-FF synchronizers (step_s, btn_s).
- Debounce: counter increments while btn_s differs from the debounced level deb and resets to 0 when btn_s equals deb. On reaching DEBOUNCE_CYCLES-1 with a mismatch, deb takes btn_s and the counter clears.
- Press event: press_evt is a one-cycle pulse on the cycle deb rises; a falling deb produces no event.
- FSM is registered; run_en and step_active are decoded from the next state, so they change on the same edge as state_o.
- finish priority: finish=1 sampled in any state forces DONE next edge; DONE exits only via reset.
- RUN: step_s=1 -> HALT.
- HALT: step_s=0 -> RUN; else press_evt -> STEP.
- STEP: instr_retired -> HALT if step_s=1, RUN if step_s=0; step_count increments on that edge.
- STEP with step_s=0 and no instr_retired: stays in STEP until retirement.
- Presses in RUN, STEP or DONE are discarded, not queued.
- step_count wraps from all-ones to 0.
- Outputs per state: run_en=1 in RUN and STEP, 0 in HALT and DONE; done=1 only in DONE; step_active=1 only in STEP.
- Simultaneous events: instr_retired and finish in the same STEP cycle -> DONE, and step_count still increments.
- Latency, press to run_en (bounce-free press): 2 sync cycles + DEBOUNCE_CYCLES + 1 FSM edge.
- Latency, stepping_flag change to state change: 3 edges.

Optional Feature:
- Macro: STEP_TIMEOUT_EN.
- Defined: a 32-bit counter clears on entering STEP and increments each STEP cycle. If it reaches TIMEOUT_CYCLES without instr_retired, the FSM goes to HALT, timeout sets (sticky until reset), and step_count does not increment.
- Undefined: no counter, timeout tied 0, STEP waits indefinitely.

Test Plan:
Use DEBOUNCE_CYCLES=4 for all scenarios.
- Reset with stepping_flag=0: release rst_n -> state_o 01 until edge 3, then 00, run_en=1; step_count=0, done=0.
- Stepping_flag 0->1 while running -> state_o 01 and run_en=0 on 3rd edge; datapath cycles frozen.
- In HALT, clean press held 10 cycles -> run_en rises exactly 7 edges after press, stays high until instr_retired pulse, then falls next edge; step_count=1.
- Press bouncing 1-0-1-0 at 1-cycle intervals then stable 1 -> exactly one STEP, step_count=1; second press during STEP ignored.
- finish asserted during RUN -> state_o 11, run_en=0, done=1 next edge; later presses and stepping_flag toggles do not change state.
- STEP_TIMEOUT_EN, TIMEOUT_CYCLES=8, no instr_retired -> HALT after 8 STEP cycles, timeout=1, step_count unchanged.
- rst_n low mid-STEP -> run_en=0 and step_count=0 immediately, without waiting for a clock edge.
